hhmm_level_seq: RTL

Sequencer for one size-2 HHMM level. Drives the level's 2-bit behaviour vector (BV) and consumes its state outputs (S0, S1) and terminate flag (T). It debounces the level's stochastic decisions into clean state-entry events, hands control to a sub-level when the chosen state owns one, and reports level termination to the parent. It sits between a parent level (or the top-level HHMM controller) and one size-2 level instance.

---
 rtl/hhmm_level_seq_if.sv | 25 ++
 rtl/hhmm_level_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hhmm_level_seq_if.sv
// Signal bundle between the level sequencer, its parent, the driven size-2 level and the sub-levels.
// The slave view belongs to the sequencer; the master view drives it.
interface hhmm_level_seq_if;
  logic       ACT;
  logic       S0;
  logic       S1;
  logic       T;
  logic       T_UP;
  logic [1:0] BV;
  logic [1:0] SUB_EN;
  logic       STATE;
  logic       STEP;
  logic       DONE;
  logic       ERR;

  modport master (
    output ACT, S0, S1, T, T_UP,
    input  BV, SUB_EN, STATE, STEP, DONE, ERR
  );

  modport slave (
    input  ACT, S0, S1, T, T_UP,
    output BV, SUB_EN, STATE, STEP, DONE, ERR
  );
endinterface

// File: rtl/hhmm_level_seq.sv
// Sequencer for one size-2 HHMM level: initialises it, debounces its decisions,
// hands off to sub-levels and reports termination or timeout to the parent.
//
// state  | meaning
// IDLE   | level asleep (BV=0), waiting for ACT
// LOAD   | level initialising (BV=3) for INIT_CYC cycles
// SEARCH | level searching (BV=1), dwell filter and timeout running
// SUB    | sub-level of the accepted state active (BV=2)
// FIN    | one-cycle DONE pulse, then back to IDLE
module hhmm_level_seq #(
  parameter int         INIT_CYC = 4,
  parameter int         DWELL    = 8,
  parameter int         TIMEOUT  = 1024,
  parameter logic [1:0] HAS_SUB  = 2'b00
) (
  input  logic               CLK,
  input  logic               INIT,
  hhmm_level_seq_if.slave    lvl
);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, SUB, FIN} state_t;

  localparam logic [7:0]  INIT_LAST  = 8'(INIT_CYC - 1);
  localparam logic [8:0]  DWELL_LAST = 9'(DWELL - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cyc, cyc_nxt;
  logic [7:0]  dwell, dwell_nxt;
  logic [15:0] tmo, tmo_nxt;
  logic [2:0]  d_prev, d_prev_nxt;
  logic [2:0]  acc, acc_nxt;
  logic        armed, armed_nxt;
  logic [1:0]  sub_en, sub_en_nxt;
  logic        state_idx, state_idx_nxt;
  logic        step, step_nxt;
  logic        err, err_nxt;
  logic [1:0]  bv;

  logic [2:0]  d;
  logic        d_valid;
  logic [8:0]  run;
  logic        accept;

  assign d       = {lvl.T, lvl.S1, lvl.S0};
  assign d_valid = (d == 3'b001) || (d == 3'b010) || (d == 3'b100);
  // run is the dwell count this cycle would produce; a held vector reaches DWELL-1 on its DWELL-th sample
  assign run     = (d_valid && (d == d_prev)) ? ({1'b0, dwell} + 9'd1) : 9'd0;
  assign accept  = d_valid && (run == DWELL_LAST) && (armed || (d != acc));

  always_comb begin
    state_nxt     = state;
    cyc_nxt       = cyc;
    dwell_nxt     = dwell;
    tmo_nxt       = tmo;
    d_prev_nxt    = d_prev;
    acc_nxt       = acc;
    armed_nxt     = armed;
    sub_en_nxt    = sub_en;
    state_idx_nxt = state_idx;
    step_nxt      = 1'b0;
    err_nxt       = err;

    case (state)
      IDLE: begin
        if (lvl.ACT) begin
          state_nxt = LOAD;
          cyc_nxt   = 8'd0;
        end
      end
      LOAD: begin
        dwell_nxt  = 8'd0;
        tmo_nxt    = 16'd0;
        armed_nxt  = 1'b0;
        acc_nxt    = 3'b000;
        d_prev_nxt = 3'b000;
        if (cyc == INIT_LAST) state_nxt = SEARCH;
        else                  cyc_nxt   = cyc + 8'd1;
      end
      SEARCH: begin
        d_prev_nxt = d;
        dwell_nxt  = run[8] ? 8'hFF : run[7:0];
        tmo_nxt    = (tmo == 16'hFFFF) ? tmo : tmo + 16'd1;
        if (d != acc) armed_nxt = 1'b1;
        if (tmo == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else if (accept) begin
          tmo_nxt   = 16'd0;
          armed_nxt = 1'b0;
          acc_nxt   = d;
          if (d[2]) begin
            state_nxt = FIN;
          end else begin
            state_idx_nxt = d[1];
            if (HAS_SUB[d[1]]) begin
              sub_en_nxt = d[1:0];
              state_nxt  = SUB;
            end else begin
              step_nxt = 1'b1;
            end
          end
        end
      end
      SUB: begin
        if (lvl.T_UP) begin
          sub_en_nxt = 2'b00;
          step_nxt   = 1'b1;
          state_nxt  = SEARCH;
          armed_nxt  = 1'b0;
          dwell_nxt  = 8'd0;
          tmo_nxt    = 16'd0;
          d_prev_nxt = 3'b000;
        end
      end
      FIN: begin
        sub_en_nxt = 2'b00;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Parent withdrawal outranks timeout and acceptance; counters are rebuilt by LOAD anyway
    if (!lvl.ACT && ((state == LOAD) || (state == SEARCH) || (state == SUB))) begin
      state_nxt     = IDLE;
      sub_en_nxt    = 2'b00;
      step_nxt      = 1'b0;
      err_nxt       = err;
      state_idx_nxt = state_idx;
    end
  end

  always_comb begin
    bv = 2'd0;
    case (state)
      LOAD:    bv = 2'd3;
      SEARCH:  bv = 2'd1;
      SUB:     bv = 2'd2;
      default: bv = 2'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state     <= IDLE;
      cyc       <= 8'd0;
      dwell     <= 8'd0;
      tmo       <= 16'd0;
      d_prev    <= 3'b000;
      acc       <= 3'b000;
      armed     <= 1'b0;
      sub_en    <= 2'b00;
      state_idx <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      dwell     <= dwell_nxt;
      tmo       <= tmo_nxt;
      d_prev    <= d_prev_nxt;
      acc       <= acc_nxt;
      armed     <= armed_nxt;
      sub_en    <= sub_en_nxt;
      state_idx <= state_idx_nxt;
      step      <= step_nxt;
      err       <= err_nxt;
    end
  end

  assign lvl.BV     = bv;
  assign lvl.SUB_EN = sub_en;
  assign lvl.STATE  = state_idx;
  assign lvl.STEP   = step;
  assign lvl.DONE   = (state == FIN);
  assign lvl.ERR    = err;

endmodule
